// File: rtl/htif_pkg.sv
// Shared HTIF encodings: host request opcodes, bridge FSM states and word widths.
package htif_pkg;

    localparam int HTIF_DATA_BITS = 64;
    localparam int HTIF_TAG_BITS  = 12;
    localparam int HTIF_LINE_BITS = 2 * HTIF_DATA_BITS;

    localparam logic [3:0] OP_RD_MEM = 4'd0;
    localparam logic [3:0] OP_WR_MEM = 4'd1;
    localparam logic [3:0] OP_RD_CR  = 4'd2;
    localparam logic [3:0] OP_WR_CR  = 4'd3;
    localparam logic [3:0] OP_START  = 4'd4;
    localparam logic [3:0] OP_STOP   = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_RESP    = 3'd4
    } htif_state_e;

endpackage

// File: rtl/htif_wmask_merge.sv
// Merges a byte-masked 64-bit host word into one half of a 128-bit memory line.
module htif_wmask_merge
    import htif_pkg::*;
(
    input  logic [HTIF_LINE_BITS-1:0] old_line,
    input  logic [HTIF_DATA_BITS-1:0] wdata,
    input  logic [7:0]                wmask,
    input  logic                      hi_sel,
    output logic [HTIF_LINE_BITS-1:0] new_line
);

    logic [HTIF_DATA_BITS-1:0] half_old;
    logic [HTIF_DATA_BITS-1:0] half_new;

    always_comb begin
        half_old = hi_sel ? old_line[HTIF_LINE_BITS-1:HTIF_DATA_BITS]
                          : old_line[HTIF_DATA_BITS-1:0];
        half_new = half_old;
        for (int i = 0; i < 8; i++) begin
            if (wmask[i]) begin
                half_new[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        new_line = old_line;
        if (hi_sel) begin
            new_line[HTIF_LINE_BITS-1:HTIF_DATA_BITS] = half_new;
        end else begin
            new_line[HTIF_DATA_BITS-1:0] = half_new;
        end
    end

endmodule

// File: rtl/htif_target_bridge.sv
// HTIF target responder: executes one host request at a time against the core's
// memory port and control registers, returning one tagged response per request.
module htif_target_bridge
    import htif_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 26,
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_TAG_BITS  = 5,
    parameter int MEM_TAG       = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      htif_req_val,
    output logic                      htif_req_rdy,
    input  logic [3:0]                htif_req_op,
    input  logic [31:0]               htif_req_addr,
    input  logic [HTIF_DATA_BITS-1:0] htif_req_data,
    input  logic [7:0]                htif_req_wmask,
    input  logic [HTIF_TAG_BITS-1:0]  htif_req_tag,
    output logic                      htif_resp_val,
    output logic [HTIF_DATA_BITS-1:0] htif_resp_data,
    output logic [HTIF_TAG_BITS-1:0]  htif_resp_tag,
    input  logic [31:0]               htif_tohost,
    output logic [31:0]               htif_fromhost,
    output logic                      htif_fromhost_wen,
    output logic                      htif_start,
    output logic                      htif_stop,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic                      mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    output logic [MEM_DATA_BITS-1:0]  mem_req_data,
    output logic [MEM_TAG_BITS-1:0]   mem_req_tag,
    input  logic                      mem_resp_val,
    input  logic [MEM_DATA_BITS-1:0]  mem_resp_data,
    input  logic [MEM_TAG_BITS-1:0]   mem_resp_tag,
    output logic [2:0]                dbg_state
);

    localparam logic [MEM_TAG_BITS-1:0] BRIDGE_TAG = MEM_TAG_BITS'(MEM_TAG);

    htif_state_e                state_q, state_d;
    logic [3:0]                 op_q, op_d;
    // Line address plus the half-select bit (byte address bits [MEM_ADDR_BITS+3:3]).
    logic [MEM_ADDR_BITS:0]     laddr_q, laddr_d;
    logic [HTIF_DATA_BITS-1:0]  wdata_q, wdata_d;
    logic [7:0]                 wmask_q, wmask_d;
    logic [HTIF_TAG_BITS-1:0]   tag_q, tag_d;
    logic [HTIF_DATA_BITS-1:0]  rdata_q, rdata_d;
    logic [MEM_DATA_BITS-1:0]   line_q, line_d;
    logic [31:0]                fromhost_q, fromhost_d;
    logic                       fromhost_wen_q, fromhost_wen_d;
    logic                       start_q, start_d;
    logic                       stop_q, stop_d;

    logic                       addr_oor;
    logic                       resp_hit;
    logic                       hi_sel;
    logic [HTIF_DATA_BITS-1:0]  resp_half;
    logic [MEM_DATA_BITS-1:0]   merged_line;
    logic                       unused_addr_bits;

    assign addr_oor  = (htif_req_addr >> (MEM_ADDR_BITS + 4)) != 32'd0;
    assign resp_hit  = mem_resp_val && (mem_resp_tag == BRIDGE_TAG);
    assign hi_sel    = laddr_q[0];
    assign resp_half = hi_sel ? mem_resp_data[MEM_DATA_BITS-1:HTIF_DATA_BITS]
                              : mem_resp_data[HTIF_DATA_BITS-1:0];
    assign unused_addr_bits = ^htif_req_addr[2:0];

    htif_wmask_merge u_merge (
        .old_line (mem_resp_data),
        .wdata    (wdata_q),
        .wmask    (wmask_q),
        .hi_sel   (hi_sel),
        .new_line (merged_line)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        laddr_d        = laddr_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        tag_d          = tag_q;
        rdata_d        = rdata_q;
        line_d         = line_q;
        fromhost_d     = fromhost_q;
        fromhost_wen_d = 1'b0;
        start_d        = start_q;
        stop_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (htif_req_val) begin
                    op_d    = htif_req_op;
                    laddr_d = htif_req_addr[MEM_ADDR_BITS+3:3];
                    wdata_d = htif_req_data;
                    wmask_d = htif_req_wmask;
                    tag_d   = htif_req_tag;
                    rdata_d = '0;
                    state_d = ST_RESP;
                    case (htif_req_op)
                        OP_RD_MEM, OP_WR_MEM: if (!addr_oor) state_d = ST_RD_REQ;
                        OP_RD_CR: rdata_d = {32'b0, htif_tohost};
                        OP_WR_CR: begin
                            fromhost_d     = htif_req_data[31:0];
                            fromhost_wen_d = 1'b1;
                        end
                        OP_START: start_d = 1'b1;
                        OP_STOP:  stop_d  = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RD_REQ: if (mem_req_rdy) state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                // Writes read the whole line first so the unmasked store keeps other bytes.
                if (resp_hit) begin
                    if (op_q == OP_RD_MEM) begin
                        rdata_d = resp_half;
                        state_d = ST_RESP;
                    end else begin
                        line_d  = merged_line;
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_WR_REQ: if (mem_req_rdy) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            laddr_q        <= '0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            tag_q          <= '0;
            rdata_q        <= '0;
            line_q         <= '0;
            fromhost_q     <= '0;
            fromhost_wen_q <= 1'b0;
            start_q        <= 1'b0;
            stop_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            laddr_q        <= laddr_d;
            wdata_q        <= wdata_d;
            wmask_q        <= wmask_d;
            tag_q          <= tag_d;
            rdata_q        <= rdata_d;
            line_q         <= line_d;
            fromhost_q     <= fromhost_d;
            fromhost_wen_q <= fromhost_wen_d;
            start_q        <= start_d;
            stop_q         <= stop_d;
        end
    end

    // Handshakes: a transfer happens on a clock edge where val && rdy; a source
    // holds val and its payload stable until that edge; responses have no ready.
    assign htif_req_rdy      = (state_q == ST_IDLE);
    assign htif_resp_val     = (state_q == ST_RESP);
    assign htif_resp_data    = rdata_q;
    assign htif_resp_tag     = tag_q;
    assign htif_fromhost     = fromhost_q;
    assign htif_fromhost_wen = fromhost_wen_q;
    assign htif_start        = start_q;
    assign htif_stop         = stop_q;
    assign mem_req_val       = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign mem_req_rw        = (state_q == ST_WR_REQ);
    assign mem_req_addr      = laddr_q[MEM_ADDR_BITS:1];
    assign mem_req_data      = line_q;
    assign mem_req_tag       = BRIDGE_TAG;
    assign dbg_state         = state_q;

endmodule
